// File: rtl/mii_rx_frame_fifo_pkg.sv
// Shared types and constants for the MII receive frame FIFO.
package mii_rx_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [3:0] NIB_PRE = 4'h5;
  localparam logic [3:0] NIB_SFD = 4'hD;

endpackage

// File: rtl/mii_rx_frame_fifo_if.sv
// MII receive pins, committed byte stream, event pulses and FSM/pointer debug taps.
// Handshake: a byte transfers on every rising clk edge where out_valid && out_ready.
interface mii_rx_frame_fifo_if #(parameter int DEPTH = 64);
  import mii_rx_pkg::*;

  localparam int PW = $clog2(DEPTH) + 1;

  logic          rx_dv;
  logic          rx_er;
  logic [3:0]    rxd;
  logic [7:0]    out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          frame_done;
  logic          frame_err;
  logic          overflow;
  state_t        dbg_state;
  logic [PW-1:0] dbg_pend;

  modport slave (
    input  rx_dv, rx_er, rxd, out_ready,
    output out_data, out_last, out_valid, frame_done, frame_err, overflow,
           dbg_state, dbg_pend
  );

  modport master (
    output rx_dv, rx_er, rxd, out_ready,
    input  out_data, out_last, out_valid, frame_done, frame_err, overflow,
           dbg_state, dbg_pend
  );

endinterface

// File: rtl/mii_rx_frame_fifo_commit_fifo.sv
// Byte buffer with a speculative write pointer, a commit pointer and a read pointer;
// the reader only sees data up to the commit pointer, and rewind discards the open frame.
module mii_rx_commit_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [8:0]                 wr_data_i,
  input  logic                       commit_i,
  input  logic                       rewind_i,
  input  logic                       rd_en_i,
  output logic [8:0]                 rd_data_o,
  output logic                       rd_valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     pend_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  logic [8:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] commit_ptr_q, commit_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  assign rd_valid_o = (rd_ptr_q != commit_ptr_q);
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o     = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
  assign pend_o     = wr_ptr_q - commit_ptr_q;

  // Commit covers a byte written on the same edge, so the pointer follows wr_ptr_d.
  always_comb begin
    wr_ptr_d     = wr_ptr_q + PW'(wr_en_i);
    commit_ptr_d = commit_ptr_q;
    if (rewind_i) begin
      wr_ptr_d = commit_ptr_q;
    end else if (commit_i) begin
      commit_ptr_d = wr_ptr_d;
    end
    rd_ptr_d = rd_ptr_q + PW'(rd_en_i && rd_valid_o);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/mii_rx_frame_fifo.sv
// MII receive capture: preamble/SFD strip, nibble-to-byte assembly, whole-frame commit.
// Optional frame/drop counters are enabled with MII_RX_FRAME_FIFO_STATS_EN.
module mii_rx_frame_fifo
  import mii_rx_pkg::*;
#(
  parameter int DEPTH        = 64,
  parameter int MIN_PREAMBLE = 2
) (
  input  logic                clk,
  input  logic                rst,
  mii_rx_frame_fifo_if.slave  bus
`ifdef MII_RX_FRAME_FIFO_STATS_EN
  ,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic [3:0]    low_q, low_d;
  logic [7:0]    pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic          done_q, done_d, err_q, err_d, ovf_q, ovf_d;
  logic          wr_en, commit, rewind, full;
  logic [8:0]    wr_data, rd_data;
  logic [PW-1:0] pend_cnt;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = phase_q;
    low_d      = low_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    wr_en      = 1'b0;
    wr_data    = {1'b0, pend_q};
    commit     = 1'b0;
    rewind     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ovf_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.rx_dv) begin
          if (bus.rxd == NIB_PRE) begin
            state_d = PRE;
            cnt_d   = 8'd1;
          end else begin
            state_d = DROP;
          end
        end
      end
      PRE: begin
        if (!bus.rx_dv) begin
          state_d = IDLE;
        end else if (bus.rx_er) begin
          rewind  = 1'b1;
          err_d   = 1'b1;
          state_d = DROP;
        end else if (bus.rxd == NIB_PRE) begin
          if (cnt_q < 8'(MIN_PREAMBLE)) cnt_d = cnt_q + 8'd1;
        end else if (bus.rxd == NIB_SFD && cnt_q >= 8'(MIN_PREAMBLE)) begin
          state_d    = DATA;
          phase_d    = 1'b0;
          pend_vld_d = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        // The newest byte is held back so the last one can be tagged when rx_dv falls.
        if (!bus.rx_dv) begin
          state_d = IDLE;
          if (!phase_q && pend_vld_q) begin
            wr_data = {1'b1, pend_q};
            if (full) begin
              rewind = 1'b1;
              ovf_d  = 1'b1;
            end else begin
              wr_en  = 1'b1;
              commit = 1'b1;
              done_d = 1'b1;
            end
          end else begin
            rewind = 1'b1;
            err_d  = 1'b1;
          end
        end else if (bus.rx_er) begin
          rewind  = 1'b1;
          err_d   = 1'b1;
          state_d = DROP;
        end else if (!phase_q) begin
          low_d   = bus.rxd;
          phase_d = 1'b1;
        end else begin
          phase_d    = 1'b0;
          pend_d     = {bus.rxd, low_q};
          pend_vld_d = 1'b1;
          if (pend_vld_q) begin
            if (full) begin
              rewind  = 1'b1;
              ovf_d   = 1'b1;
              state_d = DROP;
            end else begin
              wr_en = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (!bus.rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      low_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  mii_rx_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (wr_data),
    .commit_i   (commit),
    .rewind_i   (rewind),
    .rd_en_i    (bus.out_ready),
    .rd_data_o  (rd_data),
    .rd_valid_o (bus.out_valid),
    .full_o     (full),
    .pend_o     (pend_cnt)
  );

  assign bus.out_data   = rd_data[7:0];
  assign bus.out_last   = rd_data[8];
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.overflow   = ovf_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_pend   = pend_cnt;

`ifdef MII_RX_FRAME_FIFO_STATS_EN
  logic [15:0] frame_cnt_q, drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (done_d && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((err_d || ovf_d) && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_mii_rx_frame_fifo.sv
// Directed bench for mii_rx_frame_fifo with an expected-byte queue checked at every pop.
module tb_mii_rx_frame_fifo;
  import mii_rx_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic rst;

  mii_rx_frame_fifo_if #(.DEPTH(DEPTH)) m ();

`ifdef MII_RX_FRAME_FIFO_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
  mii_rx_frame_fifo #(.DEPTH(DEPTH), .MIN_PREAMBLE(2)) u_dut (
    .clk(clk), .rst(rst), .bus(m), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt));
`else
  mii_rx_frame_fifo #(.DEPTH(DEPTH), .MIN_PREAMBLE(2)) u_dut (
    .clk(clk), .rst(rst), .bus(m));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] exp_q [$];
  logic [7:0] tx_q [$];
  int total, bad;
  int n_done, n_err, n_ovf;
  int base_done, base_drop;
  int ready_mode;
  logic smp_valid, smp_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample/score outputs at negedge, then update out_ready just after posedge.
  task automatic tick();
    logic [9:0] e;
    @(negedge clk);
    smp_valid = m.out_valid;
    smp_done  = m.frame_done;
    if (m.frame_done) n_done++;
    if (m.frame_err)  n_err++;
    if (m.overflow)   n_ovf++;
    if (m.out_valid && m.out_ready) begin
      e = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 10'h3FF;
      check("pop_byte", 32'({1'b0, m.out_last, m.out_data}), 32'(e));
    end
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m.out_ready = 1'b0;
      1:       m.out_ready = 1'b1;
      default: m.out_ready = ~m.out_ready;
    endcase
  endtask

  task automatic nib(input logic [3:0] n, input logic er);
    m.rx_dv = 1'b1;
    m.rx_er = er;
    m.rxd   = n;
    tick();
  endtask

  task automatic idle(input int n);
    m.rx_dv = 1'b0;
    m.rx_er = 1'b0;
    m.rxd   = 4'h0;
    repeat (n) tick();
  endtask

  // Sends preamble, SFD and tx_q; pushes expected bytes when the frame should commit.
  task automatic send_frame(input int npre, input bit commit, input int er_at, input bit odd);
    for (int i = 0; i < npre; i++) nib(NIB_PRE, 1'b0);
    nib(NIB_SFD, 1'b0);
    for (int i = 0; i < tx_q.size(); i++) begin
      if (commit) exp_q.push_back({(i == tx_q.size() - 1), tx_q[i]});
      nib(tx_q[i][3:0], (er_at == 2 * i));
      nib(tx_q[i][7:4], (er_at == 2 * i + 1));
    end
    if (odd) nib(4'hA, 1'b0);
  endtask

  task automatic drain(input int max_cycles);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < max_cycles) begin
      tick();
      c++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid_now", 32'(m.out_valid), 32'd0);
    exp_q.delete();
    m.rx_dv = 1'b0;
    m.rx_er = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    base_done = n_done;
    base_drop = n_err + n_ovf;
  endtask

  int d0, e0, o0;

  initial begin
    total = 0; bad = 0; n_done = 0; n_err = 0; n_ovf = 0;
    base_done = 0; base_drop = 0;
    ready_mode = 1;
    rst = 1'b1;
    m.rx_dv = 1'b0; m.rx_er = 1'b0; m.rxd = 4'h0; m.out_ready = 1'b1;
    repeat (3) tick();
    check("reset_valid", 32'(m.out_valid), 32'd0);
    check("reset_pulses", 32'({m.frame_done, m.frame_err, m.overflow}), 32'd0);
    check("reset_state", 32'(m.dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick();
    check("idle_pend", 32'(m.dbg_pend), 32'd0);

    // Clean 3-byte frame, consumer always ready.
    d0 = n_done;
    tx_q = '{8'h12, 8'h34, 8'hAB};
    send_frame(15, 1'b1, -1, 1'b0);
    idle(1);
    check("valid_before_commit", 32'(smp_valid), 32'd0);
    tick();
    check("valid_after_dv_fall", 32'(smp_valid), 32'd1);
    check("frame_done_pulse", 32'(smp_done), 32'd1);
    idle(5);
    check("drained_t1", 32'(exp_q.size()), 32'd0);
    check("done_once_t1", 32'(n_done - d0), 32'd1);

    // rx_er on third data nibble.
    e0 = n_err; d0 = n_done;
    send_frame(15, 1'b0, 2, 1'b0);
    idle(3);
    check("err_pulse_t2", 32'(n_err - e0), 32'd1);
    check("no_done_t2", 32'(n_done - d0), 32'd0);
    check("valid_t2", 32'(smp_valid), 32'd0);
    check("pend_t2", 32'(m.dbg_pend), 32'd0);

    // DEPTH+1 byte frame with consumer stalled, then a 4-byte frame.
    ready_mode = 0;
    o0 = n_ovf; d0 = n_done;
    tx_q.delete();
    for (int i = 0; i <= DEPTH; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    send_frame(7, 1'b0, -1, 1'b0);
    idle(3);
    check("ovf_pulse_t3", 32'(n_ovf - o0), 32'd1);
    check("valid_t3", 32'(smp_valid), 32'd0);
    check("pend_t3", 32'(m.dbg_pend), 32'd0);
    tx_q = '{8'hC1, 8'h5E, 8'h00, 8'hFF};
    send_frame(4, 1'b1, -1, 1'b0);
    idle(3);
    check("valid_t3b", 32'(smp_valid), 32'd1);
    check("done_t3b", 32'(n_done - d0), 32'd1);
    ready_mode = 1;
    drain(20);

    // Odd nibble count, zero-length frame, and SFD after a too-short preamble.
    e0 = n_err; d0 = n_done; o0 = n_ovf;
    tx_q = '{8'h9C, 8'h3D};
    send_frame(6, 1'b0, -1, 1'b1);
    idle(2);
    check("err_odd", 32'(n_err - e0), 32'd1);
    tx_q.delete();
    send_frame(6, 1'b0, -1, 1'b0);
    idle(2);
    check("err_zero_len", 32'(n_err - e0), 32'd2);
    e0 = n_err;
    nib(NIB_PRE, 1'b0);
    nib(NIB_SFD, 1'b0);
    check("early_sfd_drop", 32'(m.dbg_state), 32'(DROP));
    nib(4'h1, 1'b0); nib(4'h2, 1'b0); nib(NIB_PRE, 1'b0); nib(NIB_SFD, 1'b0);
    idle(3);
    check("early_sfd_no_err", 32'(n_err - e0), 32'd0);
    check("early_sfd_no_done", 32'(n_done - d0), 32'd0);
    check("early_sfd_no_ovf", 32'(n_ovf - o0), 32'd0);
    check("early_sfd_valid", 32'(smp_valid), 32'd0);

    // Back-to-back frames with toggling ready; read pointer wraps past DEPTH.
    ready_mode = 2;
    d0 = n_done;
    tx_q = '{8'h01, 8'h02, 8'h03};
    send_frame(8, 1'b1, -1, 1'b0);
    idle(1);
    tx_q = '{8'hF4, 8'hE5, 8'hD6};
    send_frame(8, 1'b1, -1, 1'b0);
    idle(1);
    drain(40);
    idle(2);
    check("done_t5", 32'(n_done - d0), 32'd2);
    check("valid_t5", 32'(smp_valid), 32'd0);

    // Reset mid-drain.
    ready_mode = 1;
    tx_q = '{8'h77, 8'h88, 8'h99};
    send_frame(8, 1'b1, -1, 1'b0);
    idle(1);
    tick();
    do_reset();

    // Reset mid-frame while a committed frame waits.
    ready_mode = 0;
    tx_q = '{8'h4B, 8'hB4};
    send_frame(8, 1'b1, -1, 1'b0);
    idle(2);
    check("valid_pre_rst", 32'(smp_valid), 32'd1);
    tx_q = '{8'h55, 8'h66};
    send_frame(5, 1'b0, -1, 1'b0);
    do_reset();
    check("rst_state", 32'(m.dbg_state), 32'(IDLE));
    check("rst_pend", 32'(m.dbg_pend), 32'd0);

    // Capture after reset.
    ready_mode = 1;
    d0 = n_done;
    tx_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(10, 1'b1, -1, 1'b0);
    idle(1);
    drain(20);
    idle(2);
    check("done_after_rst", 32'(n_done - d0), 32'd1);

`ifdef MII_RX_FRAME_FIFO_STATS_EN
    check("frame_cnt", 32'(frame_cnt), 32'(n_done - base_done));
    check("drop_cnt", 32'(drop_cnt), 32'(n_err + n_ovf - base_drop));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
